// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: state encoding,
// address width, the dropped address value and a port-select helper.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int NUM_PORTS = 3;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Picks one per-port flag by address; the unused address reads as 0.
  function automatic logic selectPort(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    addr);
    logic r;
    r = 1'b0;
    case (addr)
      2'd0:    r = flags[0];
      2'd1:    r = flags[1];
      2'd2:    r = flags[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Control state machine for the 1x3 router. Walks one packet at a time
// through header decode, first-byte load, payload, back-pressure and
// parity handling. Outputs are a pure decode of the state register.
module router_fsm
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addrQ;

  logic [NUM_PORTS-1:0] w_emptyVec;
  logic [NUM_PORTS-1:0] w_srstVec;
  logic                 w_emptyIn;
  logic                 w_emptyQ;
  logic                 w_selSrst;

  assign w_emptyVec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_srstVec  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign w_emptyIn  = selectPort(w_emptyVec, data_in);
  assign w_emptyQ   = selectPort(w_emptyVec, r_addrQ);
  assign w_selSrst  = selectPort(w_srstVec, r_addrQ);

  // State and latched destination; a soft reset of the addressed port aborts the packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= DECODE_ADDRESS;
      r_addrQ <= '0;
    end else begin
      if (r_state == DECODE_ADDRESS && pkt_valid)
        r_addrQ <= data_in;
      if (r_state != DECODE_ADDRESS && w_selSrst) begin
        r_state <= DECODE_ADDRESS;
      end else begin
        case (r_state)
          DECODE_ADDRESS: begin
            if (pkt_valid && data_in != INVALID_ADDR)
              r_state <= w_emptyIn ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
          WAIT_TILL_EMPTY: begin
            if (w_emptyQ)
              r_state <= LOAD_FIRST_DATA;
          end
          LOAD_FIRST_DATA: r_state <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full)
              r_state <= FIFO_FULL_STATE;
            else if (!pkt_valid)
              r_state <= LOAD_PARITY;
          end
          FIFO_FULL_STATE: begin
            if (!fifo_full)
              r_state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)
              r_state <= DECODE_ADDRESS;
            else if (low_pkt_valid)
              r_state <= LOAD_PARITY;
            else
              r_state <= LOAD_DATA;
          end
          LOAD_PARITY: r_state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: begin
            r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
          end
          default: r_state <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (r_state)
      DECODE_ADDRESS:     detect_add = 1'b1;
      WAIT_TILL_EMPTY:    busy = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      default: detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: a directed vector table, hand-written
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_router_fsm;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int assertCount = 0;
  int failCount   = 0;

  // Output bundle order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy
  logic [7:0] dutOut;
  assign dutOut = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg, busy};

  localparam logic [7:0] O_IDLE  = 8'b1000_0000;
  localparam logic [7:0] O_FIRST = 8'b0100_0001;
  localparam logic [7:0] O_DATA  = 8'b0010_0100;
  localparam logic [7:0] O_AFTER = 8'b0001_0101;
  localparam logic [7:0] O_FULL  = 8'b0000_1001;
  localparam logic [7:0] O_PAR   = 8'b0000_0101;
  localparam logic [7:0] O_CHK   = 8'b0000_0011;
  localparam logic [7:0] O_WAIT  = 8'b0000_0001;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pdone;
    logic       lowpv;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    pkt_valid     = v.pv;
    data_in       = v.din;
    fifo_full     = v.full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.empty;
    {soft_reset_2, soft_reset_1, soft_reset_0} = v.srst;
    parity_done   = v.pdone;
    low_pkt_valid = v.lowpv;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expOut);
    assertCount++;
    if (dutOut !== expOut) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, dutOut, expOut, $time);
    end
  endtask

  task automatic stepCheck(input string name, input logic [7:0] expOut);
    @(posedge clock);
    #1;
    checkOutput(name, expOut);
  endtask

  task automatic clearInputs();
    vec_t v;
    v = '{pv: 1'b0, din: 2'b00, full: 1'b0, empty: 3'b111, srst: 3'b000,
          pdone: 1'b0, lowpv: 1'b0, expOut: 8'h00};
    applyStimulus(v);
  endtask

  task automatic addVec(input logic pv, input logic [1:0] din, input logic full,
                        input logic [2:0] empty, input logic pdone, input logic lowpv,
                        input logic [7:0] expOut);
    vec_t v;
    v = '{pv: pv, din: din, full: full, empty: empty, srst: 3'b000,
          pdone: pdone, lowpv: lowpv, expOut: expOut};
    vecs.push_back(v);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    clearInputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1;
  endtask

  // Reference model: packet phases and the rules for moving between them.
  localparam int P_IDLE = 0, P_WAIT = 1, P_FIRST = 2, P_DATA = 3,
                 P_FULL = 4, P_AFTER = 5, P_PAR = 6, P_CHK = 7;

  function automatic logic [7:0] phaseOut(input int ph);
    logic [7:0] tbl [8];
    tbl[P_IDLE] = O_IDLE;  tbl[P_WAIT] = O_WAIT;  tbl[P_FIRST] = O_FIRST;
    tbl[P_DATA] = O_DATA;  tbl[P_FULL] = O_FULL;  tbl[P_AFTER] = O_AFTER;
    tbl[P_PAR]  = O_PAR;   tbl[P_CHK]  = O_CHK;
    return tbl[ph];
  endfunction

  function automatic int modelNext(input int ph, input int dest, input vec_t v);
    int d;
    d = int'(v.din);
    if (ph != P_IDLE && v.srst[dest]) return P_IDLE;
    case (ph)
      P_IDLE:  if (v.pv && d != 3) return v.empty[d] ? P_FIRST : P_WAIT;
               else return P_IDLE;
      P_WAIT:  return v.empty[dest] ? P_FIRST : P_WAIT;
      P_FIRST: return P_DATA;
      P_DATA:  return v.full ? P_FULL : (!v.pv ? P_PAR : P_DATA);
      P_FULL:  return v.full ? P_FULL : P_AFTER;
      P_AFTER: return v.pdone ? P_IDLE : (v.lowpv ? P_PAR : P_DATA);
      P_PAR:   return P_CHK;
      default: return v.full ? P_FULL : P_IDLE;
    endcase
  endfunction

  initial begin
    vec_t rv;
    int   mPhase, mDest, nextPhase;

    // Reset state
    doReset();
    checkOutput("reset_idle", O_IDLE);

    // Directed table: normal packet to port 1, invalid address, busy port 2, back-pressure
    addVec(1, 2'b01, 0, 3'b111, 0, 0, O_FIRST);
    addVec(1, 2'b01, 0, 3'b111, 0, 0, O_DATA);
    addVec(1, 2'b01, 0, 3'b111, 0, 0, O_DATA);
    addVec(1, 2'b01, 0, 3'b111, 0, 0, O_DATA);
    addVec(1, 2'b01, 0, 3'b111, 0, 0, O_DATA);
    addVec(0, 2'b01, 0, 3'b111, 0, 0, O_PAR);
    addVec(0, 2'b01, 0, 3'b111, 0, 0, O_CHK);
    addVec(0, 2'b01, 0, 3'b111, 0, 0, O_IDLE);
    for (int i = 0; i < 5; i++) addVec(1, 2'b11, 0, 3'b111, 0, 0, O_IDLE);
    addVec(1, 2'b10, 0, 3'b011, 0, 0, O_WAIT);
    for (int i = 0; i < 6; i++) addVec(0, 2'b00, 0, 3'b011, 0, 0, O_WAIT);
    addVec(0, 2'b00, 0, 3'b111, 0, 0, O_FIRST);
    addVec(1, 2'b00, 0, 3'b111, 0, 0, O_DATA);
    addVec(1, 2'b00, 1, 3'b111, 0, 0, O_FULL);
    addVec(1, 2'b00, 1, 3'b111, 0, 0, O_FULL);
    addVec(0, 2'b00, 0, 3'b111, 0, 0, O_AFTER);
    addVec(0, 2'b00, 0, 3'b111, 0, 1, O_PAR);
    addVec(0, 2'b00, 0, 3'b111, 0, 0, O_CHK);
    addVec(0, 2'b00, 1, 3'b111, 0, 0, O_FULL);
    addVec(0, 2'b00, 0, 3'b111, 0, 0, O_AFTER);
    addVec(0, 2'b00, 0, 3'b111, 1, 1, O_IDLE);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      stepCheck($sformatf("vec%0d", i), vecs[i].expOut);
    end

    // Asynchronous reset in the middle of a payload
    clearInputs();
    pkt_valid = 1'b1;
    stepCheck("arst_lfd", O_FIRST);
    stepCheck("arst_ld", O_DATA);
    #3 resetn = 1'b0;
    #1 checkOutput("arst_no_clock", O_IDLE);
    @(negedge clock);
    resetn = 1'b1;
    #1 checkOutput("arst_release", O_IDLE);

    // Soft reset: other port ignored, own port aborts from LOAD_DATA
    clearInputs();
    pkt_valid = 1'b1;
    stepCheck("srst_lfd", O_FIRST);
    stepCheck("srst_ld", O_DATA);
    soft_reset_1 = 1'b1;
    stepCheck("srst_other_port", O_DATA);
    soft_reset_1 = 1'b0;
    soft_reset_0 = 1'b1;
    stepCheck("srst_own_port", O_IDLE);

    // Soft reset while parked in FIFO_FULL_STATE
    soft_reset_0 = 1'b0;
    stepCheck("srst2_lfd", O_FIRST);
    stepCheck("srst2_ld", O_DATA);
    fifo_full = 1'b1;
    stepCheck("srst2_full", O_FULL);
    stepCheck("srst2_full_hold", O_FULL);
    soft_reset_0 = 1'b1;
    stepCheck("srst2_abort", O_IDLE);
    clearInputs();
    stepCheck("srst2_idle", O_IDLE);

    // Randomized run against the reference model
    doReset();
    mPhase = P_IDLE;
    mDest  = 0;
    for (int n = 0; n < 600; n++) begin
      rv.pv    = ($urandom_range(0, 9) < 7);
      rv.din   = 2'($urandom_range(0, 3));
      rv.full  = ($urandom_range(0, 3) == 0);
      rv.empty = 3'($urandom_range(0, 7));
      rv.srst  = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 19) == 0)};
      rv.pdone = ($urandom_range(0, 4) == 0);
      rv.lowpv = ($urandom_range(0, 4) == 0);
      rv.expOut = 8'h00;
      applyStimulus(rv);
      nextPhase = modelNext(mPhase, mDest, rv);
      if (mPhase == P_IDLE && rv.pv) mDest = int'(rv.din);
      mPhase = nextPhase;
      stepCheck($sformatf("rand%0d", n), phaseOut(mPhase));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control state machine for the 1x3 router.
- Sequences the datapath for one packet at a time: header decode, first-byte load, payload load, back-pressure on FIFO full, parity load and parity check.
- Drives the register block's load/state strobes and the synchronizer's write_enb_reg and detect_add.
- Consumes fifo_full, the per-port FIFO empty flags and the per-port soft resets from the synchronizer.

Parameters:
- ADDR_W, 2, width of the destination-address field taken from the header byte.
- INVALID_ADDR, 2'b11, address value that is silently dropped; the FSM stays in DECODE_ADDRESS.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  source asserts while header/payload bytes are on data_in; deasserts on the parity byte.
- data_in  in  ADDR_W  destination address bits of the current input byte (header on the pkt_valid rising cycle).
- fifo_full  in  1  full flag of the currently addressed FIFO (from the synchronizer).
- fifo_empty_0/1/2  in  1 each  empty flags of the three output FIFOs.
- soft_reset_0/1/2  in  1 each  per-port timeout resets from the synchronizer.
- parity_done  in  1  register block has captured the parity byte.
- low_pkt_valid  in  1  register block saw pkt_valid fall while the FIFO was full.
- detect_add  out  1  header decode strobe.
- lfd_state  out  1  load-first-data state.
- ld_state  out  1  load-data state.
- laf_state  out  1  load-after-full state.
- full_state  out  1  FIFO-full state.
- write_enb_reg  out  1  FIFO write request to the synchronizer.
- rst_int_reg  out  1  clears the register block's internal parity state.
- busy  out  1  input stall to the source; the source holds data_in while high.

Behaviour:
- Outputs are Moore: decoded combinationally from the state register only, with no input-to-output paths.
- Reset (resetn=0, asynchronous): state=DECODE_ADDRESS and addr_q=0. Outputs follow the state decode: detect_add=1, all other outputs 0.
- addr_q (ADDR_W bits) loads data_in when state=DECODE_ADDRESS and pkt_valid=1; it holds otherwise.
- Selected signals: sel_empty = fifo_empty_[addr_q or data_in as noted], sel_srst = soft_reset_[addr_q].
- Soft-reset priority: in every state except DECODE_ADDRESS, sel_srst=1 forces the next state to DECODE_ADDRESS, overriding all other transitions. Soft resets of non-selected ports are ignored.
- DECODE_ADDRESS (detect_add=1, busy=0):
  - pkt_valid and data_in!=INVALID_ADDR and fifo_empty_[data_in]=1 -> LOAD_FIRST_DATA.
  - pkt_valid and data_in!=INVALID_ADDR and fifo_empty_[data_in]=0 -> WAIT_TILL_EMPTY.
  - Otherwise, including data_in=INVALID_ADDR, stay.
- WAIT_TILL_EMPTY (busy=1, write_enb_reg=0): fifo_empty_[addr_q]=1 -> LOAD_FIRST_DATA; otherwise stay.
- LOAD_FIRST_DATA (lfd_state=1, busy=1): -> LOAD_DATA unconditionally after one cycle.
- LOAD_DATA (ld_state=1, write_enb_reg=1, busy=0):
  - fifo_full=1 -> FIFO_FULL_STATE (full takes priority).
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE (full_state=1, busy=1, write_enb_reg=0): fifo_full=0 -> LOAD_AFTER_FULL; otherwise stay indefinitely.
- LOAD_AFTER_FULL (laf_state=1, busy=1, write_enb_reg=1):
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_pkt_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY (busy=1, write_enb_reg=1): -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR (rst_int_reg=1, busy=1): fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Exactly one of detect_add/lfd_state/ld_state/laf_state/full_state is high in states that own one. LOAD_PARITY, CHECK_PARITY_ERROR and WAIT_TILL_EMPTY assert none of them.
- Illegal state encodings -> DECODE_ADDRESS on the next clock.
- Reset asserted mid-packet: immediate return to DECODE_ADDRESS outputs, with no clock required.

Decomposition:
- Shared package router_pkg holds:
  - the state enum typedef (8 states, 3-bit encoding);
  - ADDR_W;
  - INVALID_ADDR;
  - the port-count constant NUM_PORTS=3.
- No sub-module; the empty/soft-reset selection is an inline mux.

Test Plan:
- Reset: hold resetn=0 for 3 clocks, then release -> detect_add=1, busy=0, write_enb_reg=0, all state strobes 0. Assert resetn=0 mid-LOAD_DATA -> outputs return to these values without a clock edge.
- Normal packet to port 1 (fifo_empty_1=1, data_in=01, pkt_valid=1, 3 payload cycles, then pkt_valid=0) -> expected sequence:
  - lfd_state=1, busy=1 (1 cycle);
  - ld_state=1, write_enb_reg=1, busy=0 (4 cycles);
  - LOAD_PARITY: write_enb_reg=1, busy=1;
  - rst_int_reg=1 (1 cycle);
  - detect_add=1.
- Invalid address: data_in=11, pkt_valid=1 for 5 cycles -> state stays DECODE_ADDRESS, busy=0, write_enb_reg never 1.
- Busy destination: data_in=10, fifo_empty_2=0 -> busy=1, write_enb_reg=0. Hold for 6 cycles, then set fifo_empty_2=1 -> lfd_state=1 on the next cycle.
- Back-pressure: raise fifo_full in LOAD_DATA -> full_state=1, write_enb_reg=0, busy=1. Drop fifo_full -> laf_state=1.
  - With low_pkt_valid=1, parity_done=0 -> LOAD_PARITY.
  - Repeat with parity_done=1 -> DECODE_ADDRESS.
- Soft reset: packet to port 0 in LOAD_DATA.
  - Pulse soft_reset_1 -> no effect.
  - Pulse soft_reset_0 -> detect_add=1 on the next cycle.
  - Repeat with soft_reset_0 in FIFO_FULL_STATE with fifo_full=1 held -> DECODE_ADDRESS.
